// File: rtl/i2c_pkg.sv
// i2c_pkg: types shared between the I2C byte/command controller and the
// bit engine.
//   bit_cmd_t   - bit-level command codes as carried on cmd_code
//   phase_t     - bit engine state (idle plus four quarter-bit phases)
//   line_lvl_t  - released(1)/pulled-low(0) level pair for SCL and SDA
//   phase_levels() - line levels a command calls for in a given phase
package i2c_pkg;

    typedef enum logic [1:0] {
        BC_START = 2'b00,
        BC_STOP  = 2'b01,
        BC_WRITE = 2'b10,
        BC_READ  = 2'b11
    } bit_cmd_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PH0,
        ST_PH1,
        ST_PH2,
        ST_PH3
    } phase_t;

    typedef struct packed {
        logic scl;
        logic sda;
    } line_lvl_t;

    // scl_prev is the level SCL was left at, because START keeps SCL where
    // it was during PH0 so a repeated start does not glitch the clock.
    function automatic line_lvl_t phase_levels(input bit_cmd_t cmd,
                                               input phase_t   ph,
                                               input logic     din,
                                               input logic     scl_prev);
        line_lvl_t lvl;
        lvl.scl = 1'b1;
        lvl.sda = 1'b1;
        case (cmd)
            BC_START: begin
                lvl.scl = (ph == ST_PH0) ? scl_prev : (ph != ST_PH3);
                lvl.sda = (ph == ST_PH0) || (ph == ST_PH1);
            end
            BC_STOP: begin
                lvl.scl = (ph != ST_PH0);
                lvl.sda = (ph == ST_PH3);
            end
            BC_WRITE: begin
                lvl.scl = (ph == ST_PH1) || (ph == ST_PH2);
                lvl.sda = din;
            end
            default: begin
                lvl.scl = (ph == ST_PH1) || (ph == ST_PH2);
                lvl.sda = 1'b1;
            end
        endcase
        return lvl;
    endfunction

endpackage

// File: rtl/i2c_sync.sv
// i2c_sync: two-flop synchronizer for an open-drain pad level.
// Resets to 1 (released bus) so the engine sees an idle bus out of reset.
//   clk, rst_n - system clock, async active-low reset
//   d          - asynchronous pad level
//   q          - synchronized level
module i2c_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/i2c_bit_engine.sv
// i2c_bit_engine: bit-level I2C PHY. Takes one START/STOP/WRITE/READ bit
// command per handshake and produces four-phase open-drain SCL/SDA timing,
// honours slave clock stretching, samples SDA and flags lost arbitration.
//   cmd_valid/cmd_ready/cmd_code/cmd_din - bit command handshake
//   rsp_valid/rsp_bit/rsp_arb_lost        - completion pulse and result
//   scl_oe/sda_oe                         - 1 pulls the line low
//   scl_i/sda_i                           - raw pad levels (asynchronous)
//
// state | meaning
// IDLE  | waiting for a command; line enables hold their last value
// PH0   | first quarter: set up SDA with SCL (normally) low
// PH1   | second quarter: release SCL; stalls while SCL is seen low
// PH2   | third quarter: SCL high; SDA sampled on its last cycle
// PH3   | fourth quarter: SCL low again (START/STOP: final levels)
module i2c_bit_engine
    import i2c_pkg::*;
#(
    parameter int QTR_CYCLES = 25
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_code,
    input  logic       cmd_din,
    output logic       rsp_valid,
    output logic       rsp_bit,
    output logic       rsp_arb_lost,
    output logic       scl_oe,
    output logic       sda_oe,
    input  logic       scl_i,
    input  logic       sda_i
);

    localparam int CNT_W = (QTR_CYCLES > 1) ? $clog2(QTR_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(QTR_CYCLES - 1);

    phase_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    bit_cmd_t         cmd_q, cmd_d;
    logic             din_q, din_d;
    logic             samp_q, samp_d;
    logic             scl_oe_q, scl_oe_d;
    logic             sda_oe_q, sda_oe_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_bit_q, rsp_bit_d;
    logic             rsp_arb_q, rsp_arb_d;

    logic             scl_s, sda_s;
    logic             last_cnt;
    logic             arb_hit;
    line_lvl_t        lvl;

    i2c_sync u_sync_scl (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (scl_i),
        .q     (scl_s)
    );

    i2c_sync u_sync_sda (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (sda_i),
        .q     (sda_s)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cmd_d       = cmd_q;
        din_d       = din_q;
        samp_d      = samp_q;
        scl_oe_d    = scl_oe_q;
        sda_oe_d    = sda_oe_q;
        rsp_valid_d = 1'b0;
        rsp_bit_d   = rsp_bit_q;
        rsp_arb_d   = rsp_arb_q;
        last_cnt    = (cnt_q == CNT_LAST);
        arb_hit     = 1'b0;
        lvl         = '{scl: 1'b1, sda: 1'b1};

        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    cmd_d   = bit_cmd_t'(cmd_code);
                    din_d   = cmd_din;
                    cnt_d   = '0;
                    state_d = ST_PH0;
                end
            end
            ST_PH0, ST_PH1, ST_PH2, ST_PH3: begin
                // Holding the count at zero covers both a stretching slave
                // and the synchronizer delay after we release SCL.
                if ((state_q == ST_PH1) && !scl_s) begin
                    cnt_d = '0;
                end else if (!last_cnt) begin
                    cnt_d = cnt_q + 1'b1;
                end else begin
                    cnt_d = '0;
                    case (state_q)
                        ST_PH0: state_d = ST_PH1;
                        ST_PH1: state_d = ST_PH2;
                        ST_PH2: begin
                            samp_d = sda_s;
                            // We released SDA for a 1 but somebody holds it low.
                            if ((cmd_q == BC_WRITE) && din_q && !sda_s) begin
                                arb_hit     = 1'b1;
                                state_d     = ST_IDLE;
                                rsp_valid_d = 1'b1;
                                rsp_arb_d   = 1'b1;
                                rsp_bit_d   = sda_s;
                            end else begin
                                state_d = ST_PH3;
                            end
                        end
                        default: begin
                            state_d     = ST_IDLE;
                            rsp_valid_d = 1'b1;
                            rsp_arb_d   = 1'b0;
                            rsp_bit_d   = ((cmd_q == BC_WRITE) || (cmd_q == BC_READ))
                                          ? samp_q : 1'b0;
                        end
                    endcase
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Enables are computed for the coming phase so they stay flat within it.
        if (state_d != ST_IDLE) begin
            lvl      = phase_levels(cmd_d, state_d, din_d, ~scl_oe_q);
            scl_oe_d = ~lvl.scl;
            sda_oe_d = ~lvl.sda;
        end
        if (arb_hit) begin
            scl_oe_d = 1'b0;
            sda_oe_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            cmd_q       <= BC_START;
            din_q       <= 1'b0;
            samp_q      <= 1'b0;
            scl_oe_q    <= 1'b0;
            sda_oe_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_bit_q   <= 1'b0;
            rsp_arb_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cmd_q       <= cmd_d;
            din_q       <= din_d;
            samp_q      <= samp_d;
            scl_oe_q    <= scl_oe_d;
            sda_oe_q    <= sda_oe_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_bit_q   <= rsp_bit_d;
            rsp_arb_q   <= rsp_arb_d;
        end
    end

    assign cmd_ready    = (state_q == ST_IDLE);
    assign rsp_valid    = rsp_valid_q;
    assign rsp_bit      = rsp_bit_q;
    assign rsp_arb_lost = rsp_arb_q;
    assign scl_oe       = scl_oe_q;
    assign sda_oe       = sda_oe_q;

endmodule

// File: tb/tb_i2c_bit_engine.sv
// Bench for i2c_bit_engine with QTR_CYCLES=4 and an open-drain bus model.
// Cycle k of a command counts from the cycle in which it is accepted (k=0).
module tb_i2c_bit_engine;
    import i2c_pkg::*;

    localparam int Q = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd_code = 2'b00;
    logic       cmd_din = 1'b0;
    logic       cmd_ready, rsp_valid, rsp_bit, rsp_arb_lost;
    logic       scl_oe, sda_oe, scl_i, sda_i;
    logic       slv_scl = 1'b0;
    logic       slv_sda = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    typedef struct {
        logic bv;
        logic arb;
        int   at;
    } exp_t;
    exp_t sb[$];

    logic sda_h[0:63];
    logic scl_h[0:63];

    i2c_bit_engine #(.QTR_CYCLES(Q)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_code     (cmd_code),
        .cmd_din      (cmd_din),
        .rsp_valid    (rsp_valid),
        .rsp_bit      (rsp_bit),
        .rsp_arb_lost (rsp_arb_lost),
        .scl_oe       (scl_oe),
        .sda_oe       (sda_oe),
        .scl_i        (scl_i),
        .sda_i        (sda_i)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign scl_i = ~scl_oe & ~slv_scl;
    assign sda_i = ~sda_oe & ~slv_sda;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_range(input string name, input bit is_sda, input int lo, input int hi,
                             input logic v);
        int   bad = -1;
        logic got = 1'b0;
        for (int k = lo; k <= hi; k++) begin
            if (bad < 0 && (is_sda ? sda_h[k] : scl_h[k]) !== v) begin
                bad = k;
                got = is_sda ? sda_h[k] : scl_h[k];
            end
        end
        n_cmp++;
        if (bad >= 0) begin
            n_bad++;
            $display("FAIL %s: cycle %0d oe=%0b expected %0b", name, bad, got, v);
        end
    endtask

    // Scoreboard monitor: every response must match the oldest expectation,
    // including the cycle it is due in.
    always @(negedge clk) begin
        if (rst_n && rsp_valid) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL rsp_unexpected: rsp_valid at cycle %0d with no command pending", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("rsp_cycle", cyc, e.at);
                check("rsp_bit", rsp_bit, e.bv);
                check("rsp_arb_lost", rsp_arb_lost, e.arb);
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (cmd_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("cmd_ready_at_issue", cmd_ready, 1);
    endtask

    // Issues a command in the current cycle and runs to its response cycle.
    // pull_sda: slave holds SDA low in cycles 1..lat-1.
    // scl_lo_to: slave holds SCL low in cycles 1..scl_lo_to.
    task automatic do_cmd(input bit_cmd_t code, input logic din, input logic pull_sda,
                          input int scl_lo_to, input int lat, input logic eb, input logic ea);
        int   base;
        exp_t e;
        wait_ready();
        base      = cyc;
        cmd_valid = 1'b1;
        cmd_code  = code;
        cmd_din   = din;
        e.bv  = eb;
        e.arb = ea;
        e.at  = base + lat;
        sb.push_back(e);
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            // A valid raised mid-command must be ignored.
            cmd_valid = (k == 3);
            cmd_code  = (k == 3) ? BC_STOP : code;
            slv_scl   = (k <= scl_lo_to);
            slv_sda   = pull_sda && (k < lat);
            sda_h[k]  = sda_oe;
            scl_h[k]  = scl_oe;
        end
        cmd_valid = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("reset_scl_oe", scl_oe, 0);
        check("reset_sda_oe", sda_oe, 0);
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_rsp_bit", rsp_bit, 0);
        check("reset_rsp_arb", rsp_arb_lost, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", cmd_ready, 1);

        do_cmd(BC_START, 1'b0, 1'b0, 0, 17, 1'b0, 1'b0);
        chk_range("start_sda_rel", 1, 1, 8, 1'b0);
        chk_range("start_sda_low", 1, 9, 16, 1'b1);
        chk_range("start_scl_rel", 0, 1, 12, 1'b0);
        chk_range("start_scl_low", 0, 13, 16, 1'b1);

        do_cmd(BC_WRITE, 1'b0, 1'b0, 0, 19, 1'b0, 1'b0);
        chk_range("wr0_sda", 1, 1, 18, 1'b1);
        chk_range("wr0_scl_ph0", 0, 1, 4, 1'b1);
        chk_range("wr0_scl_high", 0, 5, 14, 1'b0);
        chk_range("wr0_scl_ph3", 0, 15, 18, 1'b1);

        do_cmd(BC_START, 1'b0, 1'b0, 0, 19, 1'b0, 1'b0);
        chk_range("rstart_scl_ph0", 0, 1, 4, 1'b1);
        do_cmd(BC_READ, 1'b0, 1'b1, 0, 19, 1'b0, 1'b0);
        chk_range("rd_lo_sda", 1, 1, 18, 1'b0);

        do_cmd(BC_START, 1'b0, 1'b0, 0, 19, 1'b0, 1'b0);
        do_cmd(BC_READ, 1'b0, 1'b0, 0, 19, 1'b1, 1'b0);
        chk_range("rd_hi_sda", 1, 1, 18, 1'b0);
        chk_range("rd_hi_scl_high", 0, 5, 14, 1'b0);

        do_cmd(BC_START, 1'b0, 1'b0, 0, 19, 1'b0, 1'b0);
        do_cmd(BC_WRITE, 1'b0, 1'b0, 14, 29, 1'b0, 1'b0);
        chk_range("stretch_scl_high", 0, 5, 24, 1'b0);
        chk_range("stretch_scl_ph3", 0, 25, 28, 1'b1);

        do_cmd(BC_START, 1'b0, 1'b0, 0, 19, 1'b0, 1'b0);
        do_cmd(BC_WRITE, 1'b1, 1'b1, 0, 15, 1'b0, 1'b1);
        chk_range("arb_sda_rel", 1, 1, 15, 1'b0);
        chk_range("arb_scl_ph0", 0, 1, 4, 1'b1);
        chk_range("arb_scl_rel", 0, 5, 15, 1'b0);

        do_cmd(BC_STOP, 1'b0, 1'b0, 0, 19, 1'b0, 1'b0);
        chk_range("stop_sda_low", 1, 1, 14, 1'b1);
        chk_range("stop_sda_rel", 1, 15, 18, 1'b0);
        chk_range("stop_scl_ph0", 0, 1, 4, 1'b1);
        chk_range("stop_scl_rel", 0, 5, 18, 1'b0);

        // Reset in the middle of a WRITE 0 (PH0: both lines pulled low).
        wait_ready();
        cmd_valid = 1'b1;
        cmd_code  = BC_WRITE;
        cmd_din   = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        check("midwr_sda_oe_before", sda_oe, 1);
        check("midwr_scl_oe_before", scl_oe, 1);
        rst_n = 1'b0;
        #1;
        check("midrst_scl_oe", scl_oe, 0);
        check("midrst_sda_oe", sda_oe, 0);
        repeat (2) begin
            @(negedge clk);
            check("midrst_rsp_valid", rsp_valid, 0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_midrst", cmd_ready, 1);
        repeat (6) begin
            @(negedge clk);
            check("no_rsp_after_midrst", rsp_valid, 0);
        end

        check("scoreboard_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/i2c_bit_engine.md
Name: i2c_bit_engine

Overview:
- Bit-level I2C PHY that sits directly downstream of the I2C byte/command controller.
- Accepts one bit-command per handshake: START, STOP, WRITE-bit or READ-bit.
- For each command, generates four-phase open-drain SCL/SDA timing, supports slave clock stretching, samples SDA for reads, and detects loss of arbitration on written 1s.
- Pad tristates live at top level; this block drives only output-enables.

Parameters:
- QTR_CYCLES, 25, clk cycles per quarter-bit phase (≥2); 10 MHz clk gives 100 kHz SCL.
- CNT_W, $clog2(QTR_CYCLES), quarter counter width (derived, localparam).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  bit-command valid
- cmd_ready  out  1  engine idle, can accept
- cmd_code  in  2  bit_cmd_t: START=00, STOP=01, WRITE=10, READ=11
- cmd_din  in  1  data bit for WRITE; ignored otherwise
- rsp_valid  out  1  one-cycle pulse, command finished
- rsp_bit  out  1  sampled SDA (READ and WRITE); 0 for START/STOP
- rsp_arb_lost  out  1  qualifies rsp_valid: arbitration lost
- scl_oe  out  1  1 = pull SCL low
- sda_oe  out  1  1 = pull SDA low
- scl_i  in  1  SCL pad level (async)
- sda_i  in  1  SDA pad level (async)

Behaviour:
- Reset (async, rst_n low):
  - scl_oe=0, sda_oe=0, rsp_valid=0, rsp_bit=0, rsp_arb_lost=0.
  - State IDLE, counter 0, synchronizer flops 1.
  - Mid-operation reset aborts immediately and releases both lines.
- Synchronizers: scl_i and sda_i each pass through a 2-flop synchronizer; all decisions use the synced values (scl_s, sda_s).
- States: IDLE, PH0, PH1, PH2, PH3.
  - cmd_ready=1 only in IDLE.
  - Accept on cmd_valid&&cmd_ready; latch cmd_code/cmd_din; next cycle is PH0.
- Phases: each phase lasts QTR_CYCLES cycles, then advances.
- Output-enables are registered and constant within a phase. Line levels per phase (1 = released, 0 = oe asserted):
  - START: PH0 sda1/scl unchanged from previous level; PH1 sda1/scl1; PH2 sda0/scl1; PH3 sda0/scl0.
  - STOP: PH0 sda0/scl0; PH1 sda0/scl1; PH2 sda0/scl1; PH3 sda1/scl1.
  - WRITE: sda=cmd_din in all phases; scl 0,1,1,0.
  - READ: sda released in all phases; scl 0,1,1,0.
- Stretch rule: in PH1 the counter holds at 0 while scl_s==0.
  - PH1 length = QTR_CYCLES + cycles with scl_s low.
  - Includes the 2-cycle synchronizer latency after a low→released transition; no stall if SCL was already high.
- Sampling: rsp_bit captures sda_s on the last cycle of PH2 (READ, WRITE).
- Arbitration: if WRITE with cmd_din=1 samples sda_s=0 at end of PH2:
  - Release both lines and go to IDLE.
  - Pulse rsp_valid with rsp_arb_lost=1 in the next cycle; PH3 is skipped.
- Completion: rsp_valid pulses on the cycle after the last PH3 cycle. State is IDLE in that same cycle, so cmd_ready=1 and a back-to-back command is accepted in that cycle.
- rsp_bit/rsp_arb_lost hold their value until the next rsp_valid.
- Unstretched latency, accept edge = cycle 0: PH0 = 1..Q, PH1 = Q+1..2Q, PH2 = 2Q+1..3Q, PH3 = 3Q+1..4Q, rsp_valid at 4Q+1.
- cmd_valid while busy is ignored (no queue).

Decomposition:
- Package i2c_pkg holds:
  - bit_cmd_t enum (BC_START, BC_STOP, BC_WRITE, BC_READ).
  - phase/state enum.
  - Shared with the byte controller.
- Sub-module i2c_sync: 2-flop synchronizer, reset value 1, instantiated for SCL and SDA.

Test Plan (QTR_CYCLES=4; bus model: line = ~oe & ~slave_pull, pull-up default 1):
- Reset: assert rst_n low mid-WRITE → scl_oe=sda_oe=0 within the same cycle. rsp_valid stays 0; cmd_ready=1 on the first cycle after release.
- START from idle bus, accept at cycle 0:
  - sda_oe=1 from cycle 9.
  - scl_oe=1 from cycle 13.
  - rsp_valid at cycle 17, rsp_arb_lost=0.
- WRITE 0 after START:
  - sda_oe=1 cycles 1–18.
  - scl_oe=0 cycles 5–14 (PH1 stalls 2 cycles for sync).
  - rsp_valid at cycle 19, rsp_bit=0.
- READ after START with slave pulling SDA low cycles 1–18 → rsp_bit=0. Repeat with slave released → rsp_bit=1; sda_oe stays 0 throughout.
- Clock stretch: during a WRITE after START, slave holds SCL low through cycle 14 → PH1 ends at cycle 20 and rsp_valid arrives at cycle 29.
- Arbitration: WRITE 1 with slave pulling SDA low → PH3 skipped, scl_oe=sda_oe=0, rsp_valid at cycle 15 with rsp_arb_lost=1. A following STOP issued back-to-back is accepted in that same cycle.
